spi_master: RTL
===============

# spi_master

Mode-0 SPI master shift engine for the AHB SPI peripheral. It sits between the peripheral's transmit FIFO and receive FIFO. It pops one byte from the TX FIFO output, shifts it out MSB-first on MOSI while capturing MISO, and then pushes the received byte into the RX FIFO with a one-cycle strobe. SSn stays asserted across back-to-back bytes while the TX FIFO has data, and is released when the FIFO runs dry.

## Interface
Parameters:
- CLKDIV, 4: SCLK half-period in clk cycles. Legal values are 1..255; the SCLK period is 2*CLKDIV.

Ports:
- clk  input  1  system clock (HCLK); the block has one clock.
- rst  input  1  reset, synchronous, active-high (driven from ~HRESETn).
- txdin  input  8  TX byte. Valid whenever txgo is high (show-ahead FIFO output).
- txgo  input  1  a byte is available (TX FIFO not empty).
- txrdy  output  1  ready to accept a byte. The FIFO pop is txrdy & txgo.
- rxdout  output  8  last received byte. Held until the next byte completes.
- rxnew  output  1  one-cycle strobe: rxdout has just been updated.
- MISO  input  1  serial data from the slave.
- MOSI  output  1  serial data to the slave. Idles at 1.
- SCLK  output  1  serial clock. Idles at 0 (CPOL=0).
- SSn  output  1  slave select, active low. Idles at 1.

## Operation
- Reset values:
  - txrdy=1, rxnew=0, rxdout=8'h00, MOSI=1, SCLK=0, SSn=1.
  - state=IDLE, all counters 0.
- States: IDLE, LEAD, SHIFT, GAP.
- IDLE:
  - txrdy=1.
  - On an edge with txgo=1: load shreg<=txdin, MOSI<=txdin[7], SSn<=0, txrdy<=0, go to LEAD.
- LEAD: lasts CLKDIV cycles (SSn-to-first-edge setup); SCLK stays 0. Then go to SHIFT.
- SHIFT: 16 half-periods of CLKDIV cycles each; SCLK is toggled from a registered divider.
  - 0→1 edges: no data action (the slave samples MOSI).
  - 1→0 edges: MISO is captured into shreg[0] on that same clk edge, i.e. at the end of the high phase. This is mode-0 sampling with maximum margin.
  - On 1→0 edges 1..7: shreg shifts left and MOSI<=next bit.
  - On the 8th 1→0 edge: rxdout<=the completed byte, rxnew<=1, txrdy<=1, go to GAP.
- GAP: exactly one cycle; rxnew=1 and txrdy=1.
  - If txgo=1: load the next byte as in IDLE, keep SSn=0, go to LEAD.
  - Otherwise: SSn<=1, MOSI<=1, txrdy stays 1, go to IDLE.
- txgo is ignored whenever txrdy=0. txdin is sampled only on the accepting edge.
- rxnew is produced unconditionally. RX FIFO overflow policy belongs to the wrapper.
- Reset mid-transfer: on the next edge, all outputs return to their reset values. There is no rxnew and no partial byte; the TX byte already popped is lost.
- Bit counter is 3 bits and the divider counter is 8 bits. Both clear on every load and on reset.

## Timing
- Acceptance edge (txrdy & txgo) to first SCLK rise: CLKDIV cycles.
- Acceptance edge to rxnew high: 17*CLKDIV cycles (68 at CLKDIV=4).
- Back-to-back byte spacing (acceptance to acceptance): 17*CLKDIV+1 cycles. SSn stays low throughout.
- Last SCLK fall to SSn rise: 1 cycle (the GAP cycle).
- MOSI changes only on the load edge or on SCLK 1→0 edges. It never changes while SCLK=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package/header spi_pkg holds:
  - state encodings: IDLE=2'd0, LEAD=2'd1, SHIFT=2'd2, GAP=2'd3;
  - SPI_BITS=8;
  - MOSI/SSn idle level constants.
- One sub-module, spi_clkgen:
  - CLKDIV down-counter producing a one-cycle half-period tick;
  - cleared by load or reset;
  - runs only in LEAD/SHIFT.
- FSM, shift register and bit counter live in spi_master.

## Test plan
- Loopback (MOSI tied to MISO), CLKDIV=4, send 8'hA5 → rxdout=8'hA5 with rxnew high exactly 68 cycles after acceptance. The MOSI bit sequence is 1,0,1,0,0,1,0,1. SSn rises 1 cycle after the 8th SCLK fall.
- Slave model drives 8'h3C on MISO while the bench sends 8'hFF → rxdout=8'h3C and MOSI stays 1 for all 8 bits.
- Two queued bytes 8'h12, 8'h34 with txgo held high:
  - SSn stays low continuously and 16 SCLK rises are seen.
  - rxnew pulses 69 cycles apart; pops are 69 cycles apart.
- txgo toggled with changing txdin while txrdy=0 → no extra pop, and the transmitted byte is unchanged.
- rst asserted for one cycle at cycle 30 of a byte → next cycle SSn=1, SCLK=0, MOSI=1, txrdy=1, with no rxnew. A following byte 8'h5A completes correctly.
- CLKDIV=1, loopback 8'hC3:
  - SCLK period is 2 cycles;
  - rxnew is high 17 cycles after acceptance;
  - rxdout=8'hC3.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the mode-0 SPI master: FSM encodings, frame width
// and the idle levels of the serial lines.
package spi_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam int SPI_BITS = 8;

    localparam logic MOSI_IDLE = 1'b1;
    localparam logic SSN_IDLE  = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;
endpackage

// File: rtl/spi_master_if.sv
// FIFO-side handshake and serial pins of the SPI master, bundled with
// master (shift engine) and slave (FIFO wrapper / pad side) views.
interface spi_master_if;
    import spi_pkg::*;

    logic [SPI_BITS-1:0] txdin;
    logic                txgo;
    logic                txrdy;
    logic [SPI_BITS-1:0] rxdout;
    logic                rxnew;
    logic                MISO;
    logic                MOSI;
    logic                SCLK;
    logic                SSn;

    modport master (
        input  txdin, txgo, MISO,
        output txrdy, rxdout, rxnew, MOSI, SCLK, SSn
    );

    modport slave (
        output txdin, txgo, MISO,
        input  txrdy, rxdout, rxnew, MOSI, SCLK, SSn
    );
endinterface

// File: rtl/spi_clkgen.sv
// SCLK half-period timer: 8-bit down-counter that fires a one-cycle tick
// every CLKDIV cycles while running; re-armed on every byte load.
module spi_clkgen #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_tick
);
    localparam logic [7:0] RELOAD = 8'(CLKDIV - 1);

    logic [7:0] r_cnt;
    logic       w_tc;

    assign w_tc   = (r_cnt == 8'd0);
    assign o_tick = i_run & w_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (i_run) begin
            r_cnt <= w_tc ? RELOAD : r_cnt - 8'd1;
        end
    end
endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master shift engine between TX and RX FIFOs; SSn is held low
// across back-to-back bytes while the TX FIFO keeps supplying data.
//
// state | meaning
// IDLE  | SSn high, waiting for a TX byte
// LEAD  | SSn low, one half-period of setup before the first SCLK edge
// SHIFT | 16 SCLK half-periods; MISO captured and MOSI advanced on falls
// GAP   | one cycle with rxnew high; chain the next byte or release SSn
module spi_master
    import spi_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    spi_master_if.master    bus
);
    logic [1:0]          r_state;
    logic [SPI_BITS-1:0] r_shreg;
    logic [2:0]          r_bitcnt;
    logic                r_txrdy;
    logic [SPI_BITS-1:0] r_rxdout;
    logic                r_rxnew;
    logic                r_mosi;
    logic                r_sclk;
    logic                r_ssn;

    logic                w_accept;
    logic                w_run;
    logic                w_tick;
    logic [SPI_BITS-1:0] w_shifted;

    assign w_accept  = r_txrdy & bus.txgo;
    assign w_run     = (r_state == ST_LEAD) || (r_state == ST_SHIFT);
    assign w_shifted = {r_shreg[SPI_BITS-2:0], bus.MISO};

    spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_run  (w_run),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= 3'd0;
            r_txrdy  <= 1'b1;
            r_rxdout <= '0;
            r_rxnew  <= 1'b0;
            r_mosi   <= MOSI_IDLE;
            r_sclk   <= SCLK_IDLE;
            r_ssn    <= SSN_IDLE;
        end else begin
            r_rxnew <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_accept) begin
                        r_shreg  <= bus.txdin;
                        r_mosi   <= bus.txdin[SPI_BITS-1];
                        r_ssn    <= 1'b0;
                        r_txrdy  <= 1'b0;
                        r_bitcnt <= 3'd0;
                        r_state  <= ST_LEAD;
                    end else begin
                        r_ssn   <= SSN_IDLE;
                        r_mosi  <= MOSI_IDLE;
                        r_txrdy <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_LEAD: begin
                    if (w_tick) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            // Falling edge: sample MISO at the very end of the high phase.
                            r_sclk  <= 1'b0;
                            r_shreg <= w_shifted;
                            if (r_bitcnt == 3'(SPI_BITS - 1)) begin
                                r_rxdout <= w_shifted;
                                r_rxnew  <= 1'b1;
                                r_txrdy  <= 1'b1;
                                r_state  <= ST_GAP;
                            end else begin
                                r_bitcnt <= r_bitcnt + 3'd1;
                                r_mosi   <= w_shifted[SPI_BITS-1];
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.txrdy  = r_txrdy;
    assign bus.rxdout = r_rxdout;
    assign bus.rxnew  = r_rxnew;
    assign bus.MOSI   = r_mosi;
    assign bus.SCLK   = r_sclk;
    assign bus.SSn    = r_ssn;
endmodule
